// File: rtl/ps2_scan_decoder_pkg.sv
// ps2_scan_pkg: shared types and constants for the PS/2 scan-code decoder.
// Holds the decoder state encoding, the prefix byte values, the status-byte
// detector and the event entry layout used by the event sink.
package ps2_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;

  // Device status / acknowledge bytes that never form part of a key event
  localparam logic [7:0] SYS_AA = 8'hAA;
  localparam logic [7:0] SYS_FA = 8'hFA;
  localparam logic [7:0] SYS_FC = 8'hFC;
  localparam logic [7:0] SYS_FE = 8'hFE;
  localparam logic [7:0] SYS_EE = 8'hEE;
  localparam logic [7:0] SYS_00 = 8'h00;
  localparam logic [7:0] SYS_FF = 8'hFF;

  // Number of bytes following E1 that belong to the Pause sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == SYS_AA) || (b == SYS_FA) || (b == SYS_FC) || (b == SYS_FE) ||
           (b == SYS_EE) || (b == SYS_00) || (b == SYS_FF);
  endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// ps2_scan_if: byte input from the PS/2 receiver plus the key-event
// valid/ready output and status-byte reporting. The slave modport is the
// decoder; the master modport is the surrounding logic (receiver + consumer).
interface ps2_scan_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_break;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] sys_byte;
  logic       sys_byte_en;
  logic       overflow;

  modport slave (
    input  received_data, received_data_en, key_ready,
    output key_code, key_extended, key_break, key_valid,
           sys_byte, sys_byte_en, overflow
  );

  modport master (
    output received_data, received_data_en, key_ready,
    input  key_code, key_extended, key_break, key_valid,
           sys_byte, sys_byte_en, overflow
  );
endinterface

// File: rtl/ps2_scan_decoder_fifo.sv
// ps2_scan_fifo: event sink with first-word fall-through output.
// Build option PS2_SCAN_FIFO_EN: defined -> FIFO_DEPTH-entry circular FIFO,
// undefined -> single holding register. Both follow the same rules: a push
// while full is dropped and sets the sticky overflow, unless a pop happens in
// the same cycle, in which case both take effect.
module ps2_scan_fifo
  import ps2_scan_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_push,
  input  event_t i_push_data,
  input  logic   i_pop,
  output logic   o_valid,
  output event_t o_head,
  output logic   o_overflow
);

  logic r_overflow;

`ifdef PS2_SCAN_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  event_t     r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_wr;

  // Extra pointer MSB tells a full ring from an empty one
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  assign w_wr    = i_push && (!w_full || w_pop);

  // Pointer and sticky-overflow update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (i_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

  assign o_valid = !w_empty;
  assign o_head  = r_mem[r_rptr[AW-1:0]];
`else
  logic   r_valid;
  event_t r_data;
  logic   w_pop;

  assign w_pop = i_pop && r_valid;

  // Single-entry holding register with the same full/overflow behaviour
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else if (i_push && (!r_valid || w_pop)) begin
      r_data  <= i_push_data;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_data;
`endif

  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: turns the PS/2 receive byte stream into key events
// {extended, break, code}, stripping E0/F0/E1 prefixes and status bytes.
// Event sink depth is selected by PS2_SCAN_FIFO_EN (see ps2_scan_fifo).
//
//  state      | meaning
//  -----------+---------------------------------------------------
//  ST_IDLE    | no prefix pending
//  ST_EXT     | E0 seen
//  ST_BRK     | F0 seen
//  ST_EXT_BRK | E0 and F0 seen (either order)
//  ST_PAUSE   | inside E1 Pause sequence, skipping r_skip bytes
module ps2_scan_decoder
  import ps2_scan_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic      CLOCK_50,
  input logic      reset,
  ps2_scan_if.slave bus
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_skip;
  logic [2:0] w_skip_nxt;
  logic [7:0] r_sys_byte;
  logic       r_sys_byte_en;
  logic       w_sys_load;
  logic       w_push;
  event_t     w_push_data;
  logic       w_valid;
  event_t     w_head;
  logic       w_overflow;
  logic [7:0] w_byte;

  assign w_byte = bus.received_data;

  // Decoder state and Pause skip counter registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  // Next-state decode and event generation, evaluated only on byte strobes
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_push      = 1'b0;
    w_push_data = '0;
    w_sys_load  = 1'b0;
    if (bus.received_data_en) begin
      if (r_state != ST_PAUSE && is_status_byte(w_byte)) begin
        // Status bytes cancel any half-built prefix
        w_sys_load  = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_byte == BYTE_E0) begin
              w_state_nxt = ST_EXT;
            end else if (w_byte == BYTE_F0) begin
              w_state_nxt = ST_BRK;
            end else if (w_byte == BYTE_E1) begin
              w_state_nxt = ST_PAUSE;
              w_skip_nxt  = PAUSE_SKIP;
            end else begin
              w_push      = 1'b1;
              w_push_data = '{ext: 1'b0, brk: 1'b0, code: w_byte};
            end
          end
          ST_EXT: begin
            if (w_byte == BYTE_F0) begin
              w_state_nxt = ST_EXT_BRK;
            end else if (w_byte != BYTE_E0) begin
              w_push      = 1'b1;
              w_push_data = '{ext: 1'b1, brk: 1'b0, code: w_byte};
              w_state_nxt = ST_IDLE;
            end
          end
          ST_BRK: begin
            if (w_byte == BYTE_E0) begin
              w_state_nxt = ST_EXT_BRK;
            end else if (w_byte != BYTE_F0) begin
              w_push      = 1'b1;
              w_push_data = '{ext: 1'b0, brk: 1'b1, code: w_byte};
              w_state_nxt = ST_IDLE;
            end
          end
          ST_EXT_BRK: begin
            if (w_byte != BYTE_E0 && w_byte != BYTE_F0) begin
              w_push      = 1'b1;
              w_push_data = '{ext: 1'b1, brk: 1'b1, code: w_byte};
              w_state_nxt = ST_IDLE;
            end
          end
          ST_PAUSE: begin
            // The whole Pause sequence collapses into a single E1 make event
            w_skip_nxt = r_skip - 1'b1;
            if (r_skip <= 3'd1) begin
              w_skip_nxt  = '0;
              w_push      = 1'b1;
              w_push_data = '{ext: 1'b0, brk: 1'b0, code: BYTE_E1};
              w_state_nxt = ST_IDLE;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_skip_nxt  = '0;
          end
        endcase
      end
    end
  end

  // Status byte capture and one-cycle arrival pulse
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sys_byte    <= '0;
      r_sys_byte_en <= 1'b0;
    end else begin
      r_sys_byte_en <= w_sys_load;
      if (w_sys_load) r_sys_byte <= w_byte;
    end
  end

  ps2_scan_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (CLOCK_50),
    .i_rst       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (bus.key_ready),
    .o_valid     (w_valid),
    .o_head      (w_head),
    .o_overflow  (w_overflow)
  );

  assign bus.key_valid    = w_valid;
  assign bus.key_code     = w_valid ? w_head.code : 8'h00;
  assign bus.key_extended = w_valid & w_head.ext;
  assign bus.key_break    = w_valid & w_head.brk;
  assign bus.sys_byte     = r_sys_byte;
  assign bus.sys_byte_en  = r_sys_byte_en;
  assign bus.overflow     = w_overflow;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder; sink depth follows PS2_SCAN_FIFO_EN.
module tb_ps2_scan_decoder;

`ifdef PS2_SCAN_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  ps2_scan_if u_if ();

  ps2_scan_decoder #(.FIFO_DEPTH(8)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    u_if.received_data    = b;
    u_if.received_data_en = 1'b1;
    tick();
    u_if.received_data_en = 1'b0;
  endtask

  task automatic ev(input string tag, input logic e, input logic k, input logic [7:0] c);
    chk({tag, "_valid"}, {31'd0, u_if.key_valid}, 32'd1);
    chk({tag, "_event"}, {22'd0, u_if.key_extended, u_if.key_break, u_if.key_code},
        {22'd0, e, k, c});
  endtask

  task automatic pop();
    u_if.key_ready = 1'b1;
    tick();
    u_if.key_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"},  {31'd0, u_if.key_valid}, 32'd0);
    chk({tag, "_code"},   {24'd0, u_if.key_code}, 32'd0);
    chk({tag, "_flags"},  {30'd0, u_if.key_extended, u_if.key_break}, 32'd0);
    chk({tag, "_sys"},    {24'd0, u_if.sys_byte}, 32'd0);
    chk({tag, "_sys_en"}, {31'd0, u_if.sys_byte_en}, 32'd0);
    chk({tag, "_ovf"},    {31'd0, u_if.overflow}, 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] pause_seq [8];
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    u_if.received_data    = 8'h00;
    u_if.received_data_en = 1'b0;
    u_if.key_ready        = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals("rst");

    // Basic make/break/extended decode with the consumer always ready
    u_if.key_ready = 1'b1;
    strobe(8'h1C); ev("make", 1'b0, 1'b0, 8'h1C);
    strobe(8'hF0); chk("brk_pfx", {31'd0, u_if.key_valid}, 32'd0);
    strobe(8'h1C); ev("brk", 1'b0, 1'b1, 8'h1C);
    strobe(8'hE0); chk("ext_pfx", {31'd0, u_if.key_valid}, 32'd0);
    strobe(8'h75); ev("ext", 1'b1, 1'b0, 8'h75);
    strobe(8'hE0);
    strobe(8'hF0);
    strobe(8'h75); ev("extbrk", 1'b1, 1'b1, 8'h75);
    tick();
    chk("basic_drained", {31'd0, u_if.key_valid}, 32'd0);
    chk("basic_ovf", {31'd0, u_if.overflow}, 32'd0);

    // Pause sequence yields a single E1 event on its last byte
    for (int i = 0; i < 7; i++) begin
      strobe(pause_seq[i]);
      chk($sformatf("pause_quiet%0d", i), {31'd0, u_if.key_valid}, 32'd0);
    end
    strobe(pause_seq[7]); ev("pause", 1'b0, 1'b0, 8'hE1);
    tick();
    chk("pause_once", {31'd0, u_if.key_valid}, 32'd0);

    // Status byte after E0 discards the prefix
    strobe(8'hE0);
    strobe(8'hFA);
    chk("sys_en", {31'd0, u_if.sys_byte_en}, 32'd1);
    chk("sys_val", {24'd0, u_if.sys_byte}, 32'hFA);
    chk("sys_noev", {31'd0, u_if.key_valid}, 32'd0);
    tick();
    chk("sys_pulse_end", {31'd0, u_if.sys_byte_en}, 32'd0);
    chk("sys_hold", {24'd0, u_if.sys_byte}, 32'hFA);
    strobe(8'h75); ev("after_sys", 1'b0, 1'b0, 8'h75);
    tick();

    // Overflow: one push beyond capacity with no consumer
    u_if.key_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) strobe(8'(i));
    chk("ovf_at_full", {31'd0, u_if.overflow}, 32'd0);
    strobe(8'(DEPTH + 1));
    chk("ovf_set", {31'd0, u_if.overflow}, 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      ev($sformatf("drain%0d", i), 1'b0, 1'b0, 8'(i));
      pop();
    end
    chk("drain_empty", {31'd0, u_if.key_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, u_if.overflow}, 32'd1);

    // Full sink: push and pop in the same cycle keeps occupancy
    rst = 1'b1; tick(); rst = 1'b0;
    q.delete();
    for (int i = 1; i <= DEPTH; i++) begin
      strobe(8'(8'h10 + i));
      q.push_back(8'(8'h10 + i));
    end
    u_if.received_data    = 8'h2A;
    u_if.received_data_en = 1'b1;
    u_if.key_ready        = 1'b1;
    tick();
    u_if.received_data_en = 1'b0;
    u_if.key_ready        = 1'b0;
    void'(q.pop_front());
    q.push_back(8'h2A);
    chk("simul_ovf", {31'd0, u_if.overflow}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      ev($sformatf("simul%0d", i), 1'b0, 1'b0, q[i]);
      pop();
    end
    chk("simul_empty", {31'd0, u_if.key_valid}, 32'd0);

    // Reset mid-prefix returns to reset values and decodes from IDLE
    u_if.key_ready = 1'b1;
    strobe(8'hFA);
    strobe(8'hE0);
    strobe(8'hF0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_vals("midrst");
    strobe(8'h75); ev("post_rst", 1'b0, 1'b0, 8'h75);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Decodes the raw byte stream produced by the PS/2 receive path (`received_data` / `received_data_en`) into keyboard key events. Each event carries the code, an extended flag and a make/break flag. Prefixes (E0, F0, E1) and device status bytes are stripped out of the event stream. The block sits directly downstream of `PS2_Controller` and presents events through a valid/ready interface to application logic such as a character mapper or game input.

## Interface
- `FIFO_DEPTH`, 8, number of event entries; power of two, ≥2; used only when `PS2_SCAN_FIFO_EN` is defined.
- `CLOCK_50`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `received_data`  in  8  byte from the PS/2 receiver; valid only while `received_data_en` is high.
- `received_data_en`  in  1  one-cycle strobe marking a new byte.
- `key_code`  out  8  scan code of the head event; forced to 0 while `key_valid`=0.
- `key_extended`  out  1  head event was E0-prefixed; 0 while `key_valid`=0.
- `key_break`  out  1  head event is a release (F0 seen); 0 while `key_valid`=0.
- `key_valid`  out  1  head event available.
- `key_ready`  in  1  consumer accepts the head event when `key_valid` and `key_ready` are both high.
- `sys_byte`  out  8  last status byte received; holds its value between pulses.
- `sys_byte_en`  out  1  one-cycle pulse, a status byte has arrived.
- `overflow`  out  1  sticky; an event was dropped; cleared only by `reset`.

## Operation
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. All transitions happen only on cycles where `received_data_en`=1.
- Status bytes are AA, FA, FC, FE, EE, 00 and FF.
  - In IDLE, EXT, BRK or EXT_BRK, a status byte pulses `sys_byte_en`, loads `sys_byte`, and forces the FSM to IDLE. Any pending prefix is discarded.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → PAUSE with skip counter = 7.
  - Any other byte → emit {ext=0, brk=0, code}; stay in IDLE.
- EXT:
  - F0 → EXT_BRK.
  - E0 → stay in EXT.
  - Any other byte → emit {1, 0, code}; go to IDLE.
- BRK:
  - F0 → stay in BRK.
  - E0 → EXT_BRK.
  - Any other byte → emit {0, 1, code}; go to IDLE.
- EXT_BRK:
  - E0 or F0 → stay in EXT_BRK.
  - Any other byte → emit {1, 1, code}; go to IDLE.
- PAUSE:
  - Every byte decrements the 3-bit skip counter; no status-byte detection in this state.
  - The byte that takes the counter from 1 to 0 emits {0, 0, E1} and returns to IDLE.
  - Result: the whole 8-byte Pause sequence (E1 14 77 E1 F0 14 F0 77) yields exactly one event.
- Event sink: a FIFO of 10-bit entries {ext, brk, code}, or a single holding register (see Configuration).
  - Push attempted while full, with no pop in the same cycle: the event is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both take effect, occupancy is unchanged, no overflow.
  - Empty: `key_ready` is ignored.

## Timing
- Byte strobe in cycle N → event visible (`key_valid`=1 with its fields) in cycle N+1.
- Byte strobe in cycle N → `sys_byte_en` pulse in cycle N+1.
- Pop in cycle M → next entry visible in cycle M+1, or `key_valid`=0 if none. Output is first-word fall-through.
- Strobes may arrive on consecutive cycles; every strobe is processed.
- Reset values: FSM in IDLE, sink empty, `key_valid`=0, `key_code`=0, `key_extended`=0, `key_break`=0, `sys_byte`=0, `sys_byte_en`=0, `overflow`=0, skip counter=0.
- Reset mid-sequence discards any partial prefix or Pause state. The next byte is decoded from IDLE.

## Configuration
- `PS2_SCAN_FIFO_EN` defined: the sink is a `FIFO_DEPTH`-entry circular FIFO.
  - Read and write pointers are `$clog2(FIFO_DEPTH)`+1 bits; the MSB distinguishes full from empty, and pointers wrap naturally.
- `PS2_SCAN_FIFO_EN` undefined: the sink is a single register (depth 1) with identical full/overflow/simultaneous push-pop rules. `FIFO_DEPTH` is ignored.

## Structure
- Package `ps2_scan_pkg` holds:
  - FSM state encoding.
  - Byte constants E0, F0, E1 and the status-byte list, plus a status-byte detect function.
  - The event entry type {ext, brk, code[7:0]}.
- Sub-module `ps2_scan_fifo` implements the event sink and contains the `PS2_SCAN_FIFO_EN` switch. The decoder FSM lives in the top module.

## Test plan
- Bytes 1C; F0 1C; E0 75; E0 F0 75, with `key_ready`=1 → four events: {0,0,1C}, {0,1,1C}, {1,0,75}, {1,1,75}; `overflow`=0.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event {0,0,E1}; no events for bytes 14 or 77.
- E0 followed by FA → `sys_byte_en` pulse with `sys_byte`=FA, no event; then 75 → event {0,0,75} (prefix was discarded).
- `key_ready`=0, FIFO enabled with depth 8, push 9 make codes 01–09 → `overflow`=1 after the 9th. Draining yields 01–08 in order; 09 is lost.
- Fill to full, then strobe 2A in the same cycle as a pop → occupancy stays 8, `overflow` stays 0, 2A is delivered last.
- Assert `reset` after E0 F0 → outputs return to reset values; next byte 75 → event {0,0,75}.
